// File: rtl/gcd_frac_reducer.sv
// Fraction reducer: sends {num, den} to an external GCD server,
// then divides both operands by the returned g.
module gcd_frac_reducer #(
    parameter int p_nbits = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*p_nbits-1:0] istream_msg,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    output logic [2*p_nbits-1:0] gcd_req_msg,
    output logic                 gcd_req_val,
    input  logic                 gcd_req_rdy,
    input  logic [p_nbits-1:0]   gcd_resp_msg,
    input  logic                 gcd_resp_val,
    output logic                 gcd_resp_rdy,
    output logic [2*p_nbits-1:0] ostream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy
);
    localparam int N  = p_nbits;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DIV, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, g_q, g_d;
    logic [N-1:0]   qa_q, qa_d, qb_q, qb_d;
    logic [N:0]     ra_q, ra_d, rb_q, rb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           irdy_q, irdy_d, reqv_q, reqv_d;
    logic           rrdy_q, rrdy_d, ov_q, ov_d;

    logic [N:0]     ra_sh, rb_sh, gx;
    logic           ra_ge, rb_ge;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        // One restoring-division step for both operands against shared g
        gx      = {1'b0, g_q};
        ra_sh   = {ra_q[N-1:0], qa_q[N-1]};
        rb_sh   = {rb_q[N-1:0], qb_q[N-1]};
        ra_ge   = (ra_sh >= gx);
        rb_ge   = (rb_sh >= gx);

        unique case (state_q)
            S_IDLE: begin
                if (istream_val && irdy_q) begin
                    a_d     = istream_msg[2*N-1:N];
                    b_d     = istream_msg[N-1:0];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (reqv_q && gcd_req_rdy) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rrdy_q && gcd_resp_val) begin
                    g_d = gcd_resp_msg;
                    if (gcd_resp_msg == '0) begin
                        qa_d    = '0;
                        qb_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        qa_d    = a_q;
                        qb_d    = b_q;
                        ra_d    = '0;
                        rb_d    = '0;
                        cnt_d   = CW'(N);
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                ra_d  = ra_ge ? (ra_sh - gx) : ra_sh;
                rb_d  = rb_ge ? (rb_sh - gx) : rb_sh;
                qa_d  = {qa_q[N-2:0], ra_ge};
                qb_d  = {qb_q[N-2:0], rb_ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (ov_q && ostream_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        irdy_d = (state_d == S_IDLE);
        reqv_d = (state_d == S_REQ);
        rrdy_d = (state_d == S_WAIT);
        ov_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= '0;
            qa_q    <= '0;
            qb_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
            irdy_q  <= 1'b1;
            reqv_q  <= 1'b0;
            rrdy_q  <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
            irdy_q  <= irdy_d;
            reqv_q  <= reqv_d;
            rrdy_q  <= rrdy_d;
            ov_q    <= ov_d;
        end
    end

    assign istream_rdy  = irdy_q;
    assign gcd_req_val  = reqv_q;
    assign gcd_req_msg  = {a_q, b_q};
    assign gcd_resp_rdy = rrdy_q;
    assign ostream_val  = ov_q;
    assign ostream_msg  = {qa_q, qb_q};
endmodule

// File: tb/tb_gcd_frac_reducer.sv
// Bench for gcd_frac_reducer: source, GCD server and sink models
// driving one transaction at a time against a reference reduction.
module tb_gcd_frac_reducer;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   istream_msg = '0;
    logic          istream_val = 1'b0;
    logic          istream_rdy;
    logic [31:0]   gcd_req_msg;
    logic          gcd_req_val;
    logic          gcd_req_rdy = 1'b0;
    logic [15:0]   gcd_resp_msg = '0;
    logic          gcd_resp_val = 1'b0;
    logic          gcd_resp_rdy;
    logic [31:0]   ostream_msg;
    logic          ostream_val;
    logic          ostream_rdy = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit busy     = 1'b0;
    bit leak     = 1'b0;

    gcd_frac_reducer #(.p_nbits(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .istream_msg  (istream_msg),
        .istream_val  (istream_val),
        .istream_rdy  (istream_rdy),
        .gcd_req_msg  (gcd_req_msg),
        .gcd_req_val  (gcd_req_val),
        .gcd_req_rdy  (gcd_req_rdy),
        .gcd_resp_msg (gcd_resp_msg),
        .gcd_resp_val (gcd_resp_val),
        .gcd_resp_rdy (gcd_resp_rdy),
        .ostream_msg  (ostream_msg),
        .ostream_val  (ostream_val),
        .ostream_rdy  (ostream_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Input side must stay closed while a transaction is in flight
    always @(posedge clk) begin
        #3;
        if (busy && istream_rdy) leak = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] x,
                                            input logic [15:0] y);
        int p, q, t;
        p = int'(x);
        q = int'(y);
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return 16'(p);
    endfunction

    task automatic txn(input logic [15:0] a, input logic [15:0] b,
                       input int sd, input int vd, input int rd,
                       input int kd, input int exp_lat, input int abort);
        logic [15:0] g;
        logic [31:0] exp_o, held;
        int n, t0, lat;
        bit to, hb;
        g     = ref_gcd(a, b);
        exp_o = (g == 16'd0) ? 32'd0 : {a / g, b / g};
        to    = 1'b0;
        hb    = 1'b0;

        repeat (sd) @(negedge clk);
        istream_msg = {a, b};
        istream_val = 1'b1;
        n = 0;
        while (!istream_rdy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        istream_val = 1'b0;
        busy = 1'b1;

        n = 0;
        while (!gcd_req_val && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1'b1;
        repeat (vd) @(negedge clk);
        chk("req_msg", gcd_req_msg, {a, b});
        gcd_req_rdy = 1'b1;
        @(negedge clk);
        gcd_req_rdy = 1'b0;

        repeat (rd) @(negedge clk);
        gcd_resp_msg = g;
        gcd_resp_val = 1'b1;
        n = 0;
        while (!gcd_resp_rdy && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1'b1;
        @(negedge clk);
        gcd_resp_val = 1'b0;

        if (abort >= 0) begin
            repeat (abort) @(negedge clk);
            busy = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("rst_istream_rdy", 32'(istream_rdy), 32'd1);
            chk("rst_req_val", 32'(gcd_req_val), 32'd0);
            chk("rst_resp_rdy", 32'(gcd_resp_rdy), 32'd0);
            chk("rst_ostream_val", 32'(ostream_val), 32'd0);
            chk("rst_ostream_msg", ostream_msg, 32'd0);
            chk("rst_req_msg", gcd_req_msg, 32'd0);
            @(negedge clk);
            rst = 1'b1;
            chk("abort_timeout", 32'(to), 32'd0);
            return;
        end

        n = 0;
        while (!ostream_val && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) to = 1'b1;
        held = ostream_msg;
        repeat (kd) begin
            @(negedge clk);
            if (ostream_msg !== held || !ostream_val ||
                istream_rdy || gcd_req_val) hb = 1'b1;
        end
        chk("out_msg", ostream_msg, exp_o);
        busy = 1'b0;
        ostream_rdy = 1'b1;
        lat = cyc + 1 - t0;
        @(negedge clk);
        ostream_rdy = 1'b0;
        chk("out_val_drop", 32'(ostream_val), 32'd0);
        chk("hold_stable", 32'(hb), 32'd0);
        chk("timeout", 32'(to), 32'd0);
        if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [15:0] ra, rb;
        int k;
        #12;
        chk("reset_istream_rdy", 32'(istream_rdy), 32'd1);
        chk("reset_req_val", 32'(gcd_req_val), 32'd0);
        chk("reset_resp_rdy", 32'(gcd_resp_rdy), 32'd0);
        chk("reset_ostream_val", 32'(ostream_val), 32'd0);
        chk("reset_ostream_msg", ostream_msg, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        txn(16'd12, 16'd18, 0, 0, 0, 0, 19, -1);
        txn(16'd0, 16'd0, 0, 0, 0, 0, 3, -1);
        txn(16'd0, 16'd5, 0, 0, 0, 0, 19, -1);
        txn(16'd65535, 16'd65535, 0, 0, 0, 0, 19, -1);
        txn(16'd250, 16'd190, 0, 0, 0, 0, 19, -1);
        txn(16'd7, 16'd13, 1, 2, 3, 1, -1, -1);

        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
            end else begin
                k  = int'($urandom_range(1, 60));
                ra = 16'(k * int'($urandom_range(0, 65535 / k)));
                rb = 16'(k * int'($urandom_range(0, 65535 / k)));
            end
            txn(ra, rb, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), -1, -1);
        end

        txn(16'd100, 16'd75, 0, 0, 0, 5, 24, -1);

        txn(16'd48, 16'd36, 0, 0, 0, 0, -1, 5);
        txn(16'd21, 16'd49, 0, 0, 0, 0, 19, -1);

        chk("istream_rdy_leak", 32'(leak), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_frac_reducer.md
Name: gcd_frac_reducer

Overview:
- Initiator-side client of the GCD unit's request/response stream protocol.
- Accepts a fraction {num, den} on an input stream and sends the pair to an external GCD server over a request stream.
- Receives the 16-bit GCD on a response stream, divides both operands by it with a multi-cycle restoring divider, and emits the reduced fraction {num/g, den/g}.
- Sits between a producer and a GCD unit; the GCD unit's input stream connects to gcd_req and its output stream connects to gcd_resp.

Parameters:
- p_nbits, 16: operand width; all message widths derive from it. The request/input/output messages are 2*p_nbits; the response message is p_nbits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low: asserting rst low immediately resets all state.
- istream  StreamIntf recv  2*p_nbits  {num, den}; msg/val in, rdy out.
- gcd_req  StreamIntf send  2*p_nbits  {num, den} to the GCD server; msg/val out, rdy in.
- gcd_resp  StreamIntf recv  p_nbits  g from the GCD server; msg/val in, rdy out.
- ostream  StreamIntf send  2*p_nbits  {num/g, den/g}; msg/val out, rdy in.

Behaviour:
- Handshake: a transfer ("fire") occurs on a rising clk edge when val && rdy. The sender holds msg and val stable until it fires. Each rdy is a function of state only; there is no combinational val-to-rdy path.
- Exactly one transaction is in flight at a time; no overlap between transactions.
- Reset (rst low, asynchronous) forces:
  - state = IDLE;
  - istream.rdy = 1;
  - gcd_req.val = 0, gcd_resp.rdy = 0, ostream.val = 0;
  - all datapath registers = 0.
- Reset mid-transaction abandons the transaction silently. Any response the server delivers afterwards is the integrator's concern.
- FSM states:
  - IDLE: istream.rdy = 1. On istream fire, latch a = msg[2n-1:n] and b = msg[n-1:0], then go to REQ.
  - REQ: gcd_req.val = 1, gcd_req.msg = {a, b}. On fire, go to WAIT.
  - WAIT: gcd_resp.rdy = 1. On fire, latch g. If g == 0, set qa = qb = 0 and go to DONE. Otherwise initialise the divider and go to DIV.
  - DIV: exactly p_nbits cycles of restoring division, run on a/g and b/g in parallel with a shared divisor g.
    - Each cycle: rem = {rem, next dividend bit}; if rem >= g, subtract g and shift in 1, else shift in 0.
    - The remainder register is p_nbits+1 bits wide so it cannot overflow.
    - An iteration counter of clog2(p_nbits)+1 bits counts down. Go to DONE after the p_nbits-th cycle.
  - DONE: ostream.val = 1, ostream.msg = {qa, qb}; the message is held stable while rdy = 0. On fire, go to IDLE.
- Latency from istream fire to the first cycle of ostream.val, assuming zero server/sink delay:
  - 1 (REQ) + 1 (WAIT) + p_nbits (DIV) + 1 = 19 cycles for p_nbits = 16.
  - When g == 0: 3 cycles.
- Remainders are discarded. The block trusts g; if g does not divide an operand, the output is the truncated quotient. Nothing is checked or flagged.
- Boundary cases:
  - a == 0 with g != 0 gives qa = 0.
  - g == 1 passes the operands through.
  - a = b = 2^n-1 with g = 2^n-1 gives {1, 1}.
  - With p_nbits = 16, the response message is exactly the GCD unit's 16-bit output width.
- A gcd_resp.val that arrives outside WAIT is not accepted (rdy = 0) and must stay pending per the protocol.

Test Plan:
- Send {12,18}; the server model returns 6 -> gcd_req carries {12,18}; ostream = {2,3}; latency 19 with zero delays.
- Send {0,0}; the server returns 0 -> ostream = {0,0} after 3 cycles; the divider is never entered.
- Send {0,5} with g=5 -> {0,1}. Send {65535,65535} with g=65535 -> {1,1}. Send {250,190} with g=10 -> {25,19}.
- Back-to-back stream of 10 random pairs, with the server computing real GCDs and random source/sink/server delays of 0-3 cycles -> every output equals the reference reduced fraction, in order. istream.rdy stays 0 whenever state != IDLE.
- Hold ostream.rdy low for 5 cycles in DONE -> ostream.msg stays stable, no new istream accept, gcd_req.val stays 0. The transaction completes on the first rdy cycle.
- Assert rst low asynchronously mid-DIV -> all vals and gcd_resp.rdy drop immediately and istream.rdy = 1. A subsequent {21,49} with g=7 yields {3,7}.
